// File: rtl/ram_pkg.sv
// Shared definitions for the clocked byte-addressable RAM: size codes,
// sign-extend bit position and the access FSM state encoding.
package ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int SIGN_BIT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Reserved code reports 4 so the range check still sees a sane span.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/ram_byte_lane.sv
// Plain DEPTH x 8 byte array with four write lanes and four combinational
// read ports at addr+0..addr+3; lanes falling past the end read as zero.
module ram_byte_lane #(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem [DEPTH];
  logic [AW:0] lane_addr [4];
  logic [3:0]  in_range;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = {1'b0, addr} + (AW+1)'(i);
      in_range[i]  = lane_addr[i] < (AW+1)'(DEPTH);
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (in_range[i]) rdata[8*i +: 8] = mem[lane_addr[i][IW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i] && in_range[i]) mem[lane_addr[i][IW-1:0]] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/ram_sync_byteaddr.sv
// Clocked byte-addressable RAM with MOV/MOC handshake, programmable wait
// states, endian-selectable lane steering, signed loads and range checking.
module ram_sync_byteaddr
  import ram_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int AW          = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          MOV,
  input  logic          ReadWrite,
  input  logic [2:0]    MS_2_0,
  input  logic [31:0]   DataIn,
  input  logic [AW-1:0] Address,
  output logic          MOC,
  output logic [31:0]   DataOut,
  output logic          AddrErr,
  output logic [1:0]    dbg_state
);

  // Handshake: a request is taken only in IDLE on a rising MOV (sampled
  // 0 then 1); MOC pulses for one cycle per accepted request, and a new
  // MOV rise before that pulse is dropped rather than queued.

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          mov_q;
  logic          accept;

  logic          rw_q;
  logic [2:0]    ms_q;
  logic [31:0]   din_q;
  logic [AW-1:0] addr_q;

  logic [2:0]    n_bytes;
  logic [AW+1:0] last_addr;
  logic          err;
  logic [3:0]    we;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [31:0]   raw;
  logic [31:0]   rd_ext;
  logic          sgn;

  assign accept    = (state_q == IDLE) && MOV && !mov_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mov_q   <= MOV;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rw_q   <= 1'b0;
      ms_q   <= '0;
      din_q  <= '0;
      addr_q <= '0;
    end else if (accept) begin
      rw_q   <= ReadWrite;
      ms_q   <= MS_2_0;
      din_q  <= DataIn;
      addr_q <= Address;
    end
  end

  // Range check in AW+2 bits so an access near the top of the address
  // space cannot wrap back into the array.
  assign n_bytes   = size_bytes(ms_q[1:0]);
  assign last_addr = {2'b00, addr_q} + (AW+2)'(n_bytes) - (AW+2)'(1);
  assign err       = (ms_q[1:0] == SZ_RSVD) || (last_addr >= (AW+2)'(DEPTH));

  // Lane k sits at addr_q+k; it carries value byte n-1-k in big-endian
  // mode and byte k in little-endian mode.
  always_comb begin
    we    = '0;
    wdata = '0;
    raw   = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(n_bytes)) begin
        we[k] = (state_q == ACCESS) && !rw_q && !err;
        if (BIG_ENDIAN != 0) begin
          wdata[8*k +: 8]                      = din_q[8*(int'(n_bytes)-1-k) +: 8];
          raw[8*(int'(n_bytes)-1-k) +: 8]      = rdata[8*k +: 8];
        end else begin
          wdata[8*k +: 8] = din_q[8*k +: 8];
          raw[8*k +: 8]   = rdata[8*k +: 8];
        end
      end
    end
  end

  assign sgn = ms_q[SIGN_BIT];

  always_comb begin
    case (ms_q[1:0])
      SZ_BYTE: rd_ext = {{24{sgn & raw[7]}},  raw[7:0]};
      SZ_HALF: rd_ext = {{16{sgn & raw[15]}}, raw[15:0]};
      default: rd_ext = raw;
    endcase
  end

  ram_byte_lane #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_lane (
    .clk   (CLK),
    .we    (we),
    .addr  (addr_q),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MOC     <= 1'b0;
      DataOut <= '0;
      AddrErr <= 1'b0;
    end else begin
      MOC     <= (state_q == ACCESS);
      AddrErr <= (state_q == ACCESS) && err;
      if (state_q == ACCESS) begin
        if (err)       DataOut <= '0;
        else if (rw_q) DataOut <= rd_ext;
      end
    end
  end

endmodule

// File: tb/tb_ram_sync_byteaddr.sv
// Bench for ram_sync_byteaddr: unit 0 is big-endian with two wait states,
// unit 1 is little-endian with none; both share clock and reset.
module tb_ram_sync_byteaddr;

  localparam int DEPTH = 256;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [1:0]       mov = '0;
  logic [1:0]       rw = '0;
  logic [1:0][2:0]  ms = '0;
  logic [1:0][31:0] din = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0]       moc;
  logic [1:0][31:0] dout;
  logic [1:0]       aerr;
  logic [1:0][1:0]  dbg;

  int n_tests = 0;
  int n_fail  = 0;

  int wc [2] = '{2, 0};
  bit be [2] = '{1'b1, 1'b0};

  logic [7:0]  mdl_mem  [2][DEPTH];
  logic [31:0] mdl_dout [2];
  logic [31:0] exp_q [$];

  always #5 CLK = ~CLK;

  ram_sync_byteaddr #(.DEPTH(DEPTH), .AW(32), .WAIT_CYCLES(2), .BIG_ENDIAN(1)) u_be (
    .CLK(CLK), .RESET(RESET), .MOV(mov[0]), .ReadWrite(rw[0]), .MS_2_0(ms[0]),
    .DataIn(din[0]), .Address(addr[0]), .MOC(moc[0]), .DataOut(dout[0]),
    .AddrErr(aerr[0]), .dbg_state(dbg[0])
  );

  ram_sync_byteaddr #(.DEPTH(DEPTH), .AW(32), .WAIT_CYCLES(0), .BIG_ENDIAN(0)) u_le (
    .CLK(CLK), .RESET(RESET), .MOV(mov[1]), .ReadWrite(rw[1]), .MS_2_0(ms[1]),
    .DataIn(din[1]), .Address(addr[1]), .MOC(moc[1]), .DataOut(dout[1]),
    .AddrErr(aerr[1]), .dbg_state(dbg[1])
  );

  // Reference model: value bytes by significance j, placed at addr+j or
  // addr+n-1-j depending on endianness.
  function automatic void mdl_op(input int u, input logic rw_i, input logic [2:0] ms_i,
                                 input logic [31:0] din_i, input logic [31:0] a_i,
                                 output logic [31:0] e_dout, output logic e_err);
    longint a;
    int n;
    logic [31:0] val;
    a = longint'(a_i);
    n = (ms_i[1:0] == 2'd0) ? 1 : (ms_i[1:0] == 2'd1) ? 2 : 4;
    e_err = (ms_i[1:0] == 2'd3) || (a + n - 1 >= DEPTH);
    if (e_err) begin
      mdl_dout[u] = 32'd0;
    end else if (!rw_i) begin
      for (int j = 0; j < n; j++)
        mdl_mem[u][int'(a) + (be[u] ? n-1-j : j)] = 8'((din_i >> (8*j)) & 32'hFF);
    end else begin
      val = 32'd0;
      for (int j = 0; j < n; j++)
        val = val | (32'(mdl_mem[u][int'(a) + (be[u] ? n-1-j : j)]) << (8*j));
      if (ms_i[2] && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
      mdl_dout[u] = val;
    end
    e_dout = mdl_dout[u];
  endfunction

  // One MOV pulse, then wait (bounded) for MOC; lat counts edges after accept.
  task automatic do_op(input int u, input logic rw_i, input logic [2:0] ms_i,
                       input logic [31:0] din_i, input logic [31:0] a_i,
                       output logic [31:0] d_o, output logic e_o, output int lat_o,
                       output logic tail_o, output logic [31:0] ed_o, output logic ee_o);
    mdl_op(u, rw_i, ms_i, din_i, a_i, ed_o, ee_o);
    @(posedge CLK); #1;
    rw[u] = rw_i; ms[u] = ms_i; din[u] = din_i; addr[u] = a_i; mov[u] = 1'b1;
    @(posedge CLK); #1;
    mov[u] = 1'b0;
    lat_o = 0;
    while (lat_o < 40) begin
      @(posedge CLK);
      lat_o++;
      #1;
      if (moc[u]) break;
    end
    d_o = dout[u];
    e_o = aerr[u];
    @(posedge CLK); #1;
    tail_o = moc[u];
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      n_tests++; if (moc[u] !== 1'b0) begin n_fail++; $display("FAIL reset_moc u%0d got %b want 0", u, moc[u]); end
      n_tests++; if (dout[u] !== 32'd0) begin n_fail++; $display("FAIL reset_dout u%0d got %h want 0", u, dout[u]); end
      n_tests++; if (aerr[u] !== 1'b0) begin n_fail++; $display("FAIL reset_aerr u%0d got %b want 0", u, aerr[u]); end
      n_tests++; if (dbg[u] !== 2'd0) begin n_fail++; $display("FAIL reset_state u%0d got %0d want 0", u, dbg[u]); end
    end
  endtask

  task automatic test_preload();
    logic [31:0] d, ed; logic e, ee, t; int lat;
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < DEPTH; a += 4) begin
        do_op(u, 1'b0, 3'b010, $urandom, 32'(a), d, e, lat, t, ed, ee);
        n_tests++; if (e !== 1'b0 || lat != wc[u] + 1) begin
          n_fail++; $display("FAIL preload u%0d a%0d got err=%b lat=%0d want err=0 lat=%0d", u, a, e, lat, wc[u] + 1);
        end
      end
    end
  endtask

  task automatic test_big_endian();
    logic [31:0] d, ed; logic e, ee, t; int lat;
    logic [31:0] want [4] = '{32'hC0, 32'h00, 32'h00, 32'h01};
    do_op(0, 1'b0, 3'b010, 32'hC000_0001, 32'd13, d, e, lat, t, ed, ee);
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1'b1, 3'b000, 32'd0, 32'(13 + i), d, e, lat, t, ed, ee);
      n_tests++; if (d !== want[i] || e !== 1'b0) begin
        n_fail++; $display("FAIL be_byte @%0d got %h err=%b want %h err=0", 13 + i, d, e, want[i]);
      end
      n_tests++; if (lat != 3 || t !== 1'b0) begin
        n_fail++; $display("FAIL be_latency @%0d got lat=%0d tail=%b want lat=3 tail=0", 13 + i, lat, t);
      end
    end
  endtask

  task automatic test_little_endian();
    logic [31:0] d, ed; logic e, ee, t; int lat;
    do_op(1, 1'b0, 3'b010, 32'h1122_3344, 32'd20, d, e, lat, t, ed, ee);
    do_op(1, 1'b1, 3'b001, 32'd0, 32'd20, d, e, lat, t, ed, ee);
    n_tests++; if (d !== 32'h0000_3344) begin n_fail++; $display("FAIL le_half got %h want 00003344", d); end
    n_tests++; if (lat != 1 || t !== 1'b0) begin n_fail++; $display("FAIL wait0_latency got lat=%0d tail=%b want lat=1 tail=0", lat, t); end
    do_op(1, 1'b1, 3'b000, 32'd0, 32'd23, d, e, lat, t, ed, ee);
    n_tests++; if (d !== 32'h0000_0011) begin n_fail++; $display("FAIL le_byte got %h want 00000011", d); end
  endtask

  task automatic test_signed();
    logic [31:0] d, ed; logic e, ee, t; int lat;
    do_op(0, 1'b0, 3'b000, 32'h0000_00FF, 32'd0, d, e, lat, t, ed, ee);
    do_op(0, 1'b1, 3'b000, 32'd0, 32'd0, d, e, lat, t, ed, ee);
    n_tests++; if (d !== 32'h0000_00FF) begin n_fail++; $display("FAIL byte_unsigned got %h want 000000ff", d); end
    do_op(0, 1'b1, 3'b100, 32'd0, 32'd0, d, e, lat, t, ed, ee);
    n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL byte_signed got %h want ffffffff", d); end
    do_op(0, 1'b0, 3'b001, 32'h0000_8001, 32'd2, d, e, lat, t, ed, ee);
    do_op(0, 1'b1, 3'b101, 32'd0, 32'd2, d, e, lat, t, ed, ee);
    n_tests++; if (d !== 32'hFFFF_8001) begin n_fail++; $display("FAIL half_signed got %h want ffff8001", d); end
  endtask

  task automatic test_addr_err();
    logic [31:0] d, ed; logic e, ee, t; int lat;
    logic [7:0] old255;
    do_op(0, 1'b1, 3'b010, 32'd0, 32'd100, d, e, lat, t, ed, ee);
    do_op(0, 1'b1, 3'b010, 32'd0, 32'd253, d, e, lat, t, ed, ee);
    n_tests++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL err_read253 got err=%b d=%h want err=1 d=0", e, d); end
    old255 = mdl_mem[0][255];
    do_op(0, 1'b0, 3'b010, 32'h5A5A_5A5A, 32'd255, d, e, lat, t, ed, ee);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_write255 got err=%b want 1", e); end
    do_op(0, 1'b1, 3'b000, 32'd0, 32'd255, d, e, lat, t, ed, ee);
    n_tests++; if (d !== {24'd0, old255} || e !== 1'b0) begin
      n_fail++; $display("FAIL byte255_kept got %h err=%b want %h err=0", d, e, {24'd0, old255});
    end
    do_op(0, 1'b1, 3'b011, 32'd0, 32'd0, d, e, lat, t, ed, ee);
    n_tests++; if (e !== 1'b1 || d !== 32'd0 || lat != 3) begin
      n_fail++; $display("FAIL err_rsvd got err=%b d=%h lat=%0d want err=1 d=0 lat=3", e, d, lat);
    end
    do_op(0, 1'b1, 3'b010, 32'd0, 32'hFFFF_FFFE, d, e, lat, t, ed, ee);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_nowrap got err=%b want 1", e); end
    @(posedge CLK); #1;
    n_tests++; if (aerr[0] !== 1'b0) begin n_fail++; $display("FAIL aerr_idle got %b want 0", aerr[0]); end
  endtask

  task automatic test_mov_level();
    logic [31:0] ed; logic ee; int cnt;
    mdl_op(0, 1'b1, 3'b010, 32'd0, 32'd100, ed, ee);
    @(posedge CLK); #1;
    rw[0] = 1'b1; ms[0] = 3'b010; addr[0] = 32'd100; mov[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin @(posedge CLK); #1; if (moc[0]) cnt++; end
    mov[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge CLK); #1; if (moc[0]) cnt++; end
    n_tests++; if (cnt != 1) begin n_fail++; $display("FAIL mov_level_moc_count got %0d want 1", cnt); end
    n_tests++; if (dout[0] !== ed) begin n_fail++; $display("FAIL mov_level_data got %h want %h", dout[0], ed); end
  endtask

  task automatic test_repulse();
    logic [31:0] ed; logic ee; int cnt;
    mdl_op(0, 1'b1, 3'b001, 32'd0, 32'd40, ed, ee);
    @(posedge CLK); #1;
    rw[0] = 1'b1; ms[0] = 3'b001; addr[0] = 32'd40; mov[0] = 1'b1;
    @(posedge CLK); #1; mov[0] = 1'b0;
    cnt = 0;
    @(posedge CLK); #1; mov[0] = 1'b1;
    if (moc[0]) cnt++;
    @(posedge CLK); #1; mov[0] = 1'b0;
    if (moc[0]) cnt++;
    for (int i = 0; i < 12; i++) begin @(posedge CLK); #1; if (moc[0]) cnt++; end
    n_tests++; if (cnt != 1) begin n_fail++; $display("FAIL repulse_moc_count got %0d want 1", cnt); end
    n_tests++; if (dout[0] !== ed) begin n_fail++; $display("FAIL repulse_data got %h want %h", dout[0], ed); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, ed; logic e, ee, t; int lat, cnt;
    @(posedge CLK); #1;
    rw[0] = 1'b0; ms[0] = 3'b010; din[0] = 32'hDEAD_BEEF; addr[0] = 32'd8; mov[0] = 1'b1;
    @(posedge CLK); #1; mov[0] = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    cnt = 0;
    #1;
    n_tests++; if (dout[0] !== 32'd0 || aerr[0] !== 1'b0 || moc[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs got moc=%b d=%h err=%b want 0 0 0", moc[0], dout[0], aerr[0]);
    end
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    mdl_dout[0] = 32'd0;
    mdl_dout[1] = 32'd0;
    for (int i = 0; i < 8; i++) begin @(posedge CLK); #1; if (moc[0]) cnt++; end
    n_tests++; if (cnt != 0) begin n_fail++; $display("FAIL reset_mid_moc got %0d pulses want 0", cnt); end
    n_tests++; if (dout[1] !== 32'd0) begin n_fail++; $display("FAIL reset_mid_dout_u1 got %h want 0", dout[1]); end
    do_op(0, 1'b1, 3'b010, 32'd0, 32'd8, d, e, lat, t, ed, ee);
    n_tests++; if (d !== ed || e !== 1'b0) begin n_fail++; $display("FAIL reset_mid_old_data got %h err=%b want %h err=0", d, e, ed); end
  endtask

  task automatic test_random();
    logic [31:0] d, ed, a, exp_d; logic e, ee, t, r; int lat, u, k;
    logic [2:0] m;
    for (int i = 0; i < 300; i++) begin
      u = $urandom_range(0, 1);
      r = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 9);
      m[1:0] = (k < 3) ? 2'd0 : (k < 6) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
      m[2] = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                       : 32'($urandom_range(0, DEPTH + 3));
      do_op(u, r, m, $urandom, a, d, e, lat, t, ed, ee);
      exp_q.push_back(ed);
      exp_d = exp_q.pop_front();
      n_tests++; if (d !== exp_d || e !== ee || lat != wc[u] + 1 || t !== 1'b0) begin
        n_fail++;
        $display("FAIL random#%0d u%0d rw=%b ms=%b a=%h got d=%h err=%b lat=%0d tail=%b want d=%h err=%b lat=%0d tail=0",
                 i, u, r, m, a, d, e, lat, t, exp_d, ee, wc[u] + 1);
      end
    end
  endtask

  initial begin
    mdl_dout[0] = 32'd0;
    mdl_dout[1] = 32'd0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    test_reset();
    test_preload();
    test_big_endian();
    test_little_endian();
    test_signed();
    test_addr_err();
    test_mov_level();
    test_repulse();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sync_byteaddr.md
Name: ram_sync_byteaddr

Overview:
- Clocked, parametrised byte-addressable data/instruction RAM for the ARM datapath.
- Successor to the fixed 256x8 asynchronous RAM. Keeps the MOV/MOC handshake and the MS_2_0 size encoding.
- Adds a real clock and asynchronous reset, configurable depth and wait states, signed loads, big/little-endian selection and an address-error flag.
- Sits between the control unit (drives MOV, MOC handling in the CPU state machine) and the MAR/MDR datapath.

Parameters:
- DEPTH, 256, memory size in bytes; any value >= 4.
- AW, 32, width of Address.
- WAIT_CYCLES, 2, extra cycles between request accept and MOC; 0..15.
- BIG_ENDIAN, 1, 1 = byte at Address is the most-significant byte of the access; 0 = least-significant.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MOV  in  1  memory operation valid (request).
- ReadWrite  in  1  1 = read, 0 = write.
- MS_2_0  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 reserved); [2] sign-extend on read.
- DataIn  in  32  write data, right-justified.
- Address  in  AW  byte address; misaligned allowed.
- MOC  out  1  memory operation complete, one-cycle pulse.
- DataOut  out  32  read data, right-justified, zero- or sign-extended.
- AddrErr  out  1  valid with MOC; 1 = access rejected.

Behaviour:
- Reset (async assert, sync release): state IDLE; MOC=0, DataOut=0, AddrErr=0; MOV edge register cleared. Memory array is NOT cleared.
- Request accept: in IDLE at a rising CLK edge where MOV=1 and the previously sampled MOV=0.
  - Accepting latches ReadWrite, MS_2_0, DataIn and Address.
  - MOV held high does not retrigger. Both the 1-cycle MOV pulse and a level MOV are legal.
- MOV rising while not IDLE is ignored. It is not queued; the CPU must wait for MOC.
- States and transitions:
  - IDLE: on accept, go to WAIT if WAIT_CYCLES>0, else ACCESS.
  - WAIT: down-counter loaded with WAIT_CYCLES-1; go to ACCESS when it reaches 0.
  - ACCESS: perform the array read/write; MOC=1 for exactly this cycle's output; return to IDLE.
- Latency: accept at edge k, MOC high after edge k+WAIT_CYCLES+1, low after the next edge.
- Size: N = 1, 2 or 4 bytes. The bytes occupy Address..Address+N-1.
  - BIG_ENDIAN=1: Address holds bits [8N-1:8N-8].
  - BIG_ENDIAN=0: Address holds bits [7:0].
- Write: only the low 8N bits of DataIn are stored. Other locations are unchanged. DataOut is unchanged.
- Read:
  - DataOut updates at the ACCESS edge and holds until the next successful read.
  - Upper 32-8N bits are zero when MS_2_0[2]=0. They are copies of bit 8N-1 when MS_2_0[2]=1.
  - MS_2_0[2] is ignored for word accesses and for writes.
- Error: AddrErr=1 with MOC when MS_2_0[1:0]=11 or Address+N-1 >= DEPTH.
  - The address computation has no wrap-around.
  - On error: no write occurs, DataOut is forced to 0, and MOC still pulses.
  - AddrErr=0 on successful accesses; it is held 0 outside MOC.
- Reset mid-operation: the operation is aborted, the write is not performed, and no MOC is produced.
- Read of a never-written location returns X in simulation. Benches preload via writes.

Decomposition:
- Shared package (ram_pkg):
  - Size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - Signed-bit index.
  - State encoding IDLE, WAIT, ACCESS.
- Sub-module ram_byte_lane: a pure byte array of DEPTH x 8 with a 4-lane write enable and 4 read ports at Address+0..3.
- The top holds the FSM, lane steering/endian swap, extension and error logic.

Test Plan:
- Reset during WAIT of a word write 0xDEADBEEF @ Address 8 -> no MOC; MOC=0, DataOut=0, AddrErr=0; a later word read @ 8 shows the old contents.
- BIG_ENDIAN=1, WAIT_CYCLES=2: word write 0xC0000001 @ 13, then byte reads @ 13..16 -> 0xC0, 0x00, 0x00, 0x01; each MOC arrives 3 edges after accept.
- BIG_ENDIAN=0: word write 0x11223344 @ 20, then half read @ 20 -> 0x00003344; byte read @ 23 -> 0x00000011.
- Signed loads: byte write 0xFF @ 0, then read with MS_2_0=000 -> 0x000000FF; with MS_2_0=100 -> 0xFFFFFFFF. Half 0x8001 read with 101 -> 0xFFFF8001.
- DEPTH=256: word read @ 253 -> AddrErr=1, DataOut=0; word write @ 255 -> AddrErr=1 and byte 255 unchanged; MS_2_0=011 -> AddrErr=1.
- MOV held high for 10 cycles -> exactly one MOC. A MOV re-pulse during WAIT -> ignored, one MOC. WAIT_CYCLES=0 -> MOC one edge after accept.
